// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry and mret return sequencer.
// Picks the highest-priority exception/interrupt at the decode boundary,
// pulses the CSR strobes for one cycle, then holds a fetch redirect until
// it is accepted. Every output is a register; no input reaches an output
// without passing through the state register.
module trap_ctrl #(
  parameter logic [31:0] MTVEC_BASE = 32'h0000_0100,
  parameter bit          VECTORED   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_i,
  input  logic [31:0] pc_i,
  input  logic        illegal_insn_i,
  input  logic        ebreak_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic        mie_i,
  input  logic [31:0] epc_i,
  output logic        save_epc_o,
  output logic [31:0] epc_pc_o,
  output logic        mcause_we_o,
  output logic [31:0] mcause_o,
  output logic        restore_mie_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state_r;
  logic        mret_r;
  logic [31:0] target_r;

  logic        event_s;
  logic        is_mret_s;
  logic [31:0] cause_s;
  logic [31:0] target_s;

  // Trap vector for a cause: interrupts may be vectored, exceptions never are.
  function automatic logic [31:0] trap_target(input logic is_irq, input logic [31:0] cause);
    logic [31:0] tgt;
    if (is_irq && VECTORED) begin
      tgt = MTVEC_BASE + {25'd0, cause[4:0], 2'b00};
    end else begin
      tgt = MTVEC_BASE;
    end
    return tgt;
  endfunction

  // Priority decode of the decode-stage event; interrupts are masked by MIE only.
  always_comb begin
    event_s   = 1'b0;
    is_mret_s = 1'b0;
    cause_s   = 32'h0000_0000;
    target_s  = MTVEC_BASE;
    if (instr_valid_i) begin
      if (illegal_insn_i) begin
        event_s  = 1'b1;
        cause_s  = 32'h0000_0002;
        target_s = trap_target(1'b0, 32'h0000_0002);
      end else if (ebreak_i) begin
        event_s  = 1'b1;
        cause_s  = 32'h0000_0003;
        target_s = trap_target(1'b0, 32'h0000_0003);
      end else if (ecall_i) begin
        event_s  = 1'b1;
        cause_s  = 32'h0000_000B;
        target_s = trap_target(1'b0, 32'h0000_000B);
      end else if (mret_i) begin
        event_s   = 1'b1;
        is_mret_s = 1'b1;
      end else if (irq_ext_i && mie_i) begin
        event_s  = 1'b1;
        cause_s  = 32'h8000_000B;
        target_s = trap_target(1'b1, 32'h8000_000B);
      end else if (irq_timer_i && mie_i) begin
        event_s  = 1'b1;
        cause_s  = 32'h8000_0007;
        target_s = trap_target(1'b1, 32'h8000_0007);
      end else begin
        event_s = 1'b0;
      end
    end else begin
      event_s = 1'b0;
    end
  end

  // Sequencer FSM with registered outputs for the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      mret_r           <= 1'b0;
      target_r         <= 32'h0000_0000;
      save_epc_o       <= 1'b0;
      epc_pc_o         <= 32'h0000_0000;
      mcause_we_o      <= 1'b0;
      mcause_o         <= 32'h0000_0000;
      restore_mie_o    <= 1'b0;
      flush_o          <= 1'b0;
      stall_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (event_s) begin
            state_r       <= SAVE;
            mret_r        <= is_mret_s;
            target_r      <= target_s;
            save_epc_o    <= ~is_mret_s;
            mcause_we_o   <= ~is_mret_s;
            restore_mie_o <= is_mret_s;
            epc_pc_o      <= is_mret_s ? 32'h0000_0000 : pc_i;
            mcause_o      <= is_mret_s ? 32'h0000_0000 : cause_s;
            flush_o       <= 1'b1;
            stall_o       <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SAVE: begin
          state_r          <= REDIRECT;
          save_epc_o       <= 1'b0;
          epc_pc_o         <= 32'h0000_0000;
          mcause_we_o      <= 1'b0;
          mcause_o         <= 32'h0000_0000;
          restore_mie_o    <= 1'b0;
          flush_o          <= 1'b0;
          stall_o          <= 1'b1;
          redirect_valid_o <= 1'b1;
          // mret returns to the mepc value visible while the strobes fire
          target_r         <= mret_r ? epc_i : target_r;
          redirect_pc_o    <= mret_r ? epc_i : target_r;
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            state_r          <= IDLE;
            stall_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= 32'h0000_0000;
          end else begin
            state_r <= REDIRECT;
          end
        end
        default: begin
          state_r          <= IDLE;
          save_epc_o       <= 1'b0;
          epc_pc_o         <= 32'h0000_0000;
          mcause_we_o      <= 1'b0;
          mcause_o         <= 32'h0000_0000;
          restore_mie_o    <= 1'b0;
          flush_o          <= 1'b0;
          stall_o          <= 1'b0;
          redirect_valid_o <= 1'b0;
          redirect_pc_o    <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a non-vectored and a vectored instance share
// the stimulus; a transaction-level model predicts each output cycle.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, illegal, ebreak, ecall, mret, irq_ext, irq_timer, mie, ready;
  logic [31:0] pc, epc;

  logic [1:0]  o_save, o_mcause_we, o_restore, o_flush, o_stall, o_valid;
  logic [31:0] o_epc [2];
  logic [31:0] o_cause [2];
  logic [31:0] o_rpc [2];

  int n_cmp = 0;
  int n_bad = 0;

  // model: per instance, whether a sequence is running and how old it is
  logic        m_busy [2];
  int          m_age [2];
  logic        m_mret [2];
  logic [31:0] m_pc [2];
  logic [31:0] m_cause [2];
  logic [31:0] m_target [2];

  always #5 clk = ~clk;

  trap_ctrl #(.MTVEC_BASE(32'h0000_0100), .VECTORED(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .pc_i(pc),
    .illegal_insn_i(illegal), .ebreak_i(ebreak), .ecall_i(ecall), .mret_i(mret),
    .irq_ext_i(irq_ext), .irq_timer_i(irq_timer), .mie_i(mie), .epc_i(epc),
    .save_epc_o(o_save[0]), .epc_pc_o(o_epc[0]), .mcause_we_o(o_mcause_we[0]),
    .mcause_o(o_cause[0]), .restore_mie_o(o_restore[0]), .flush_o(o_flush[0]),
    .stall_o(o_stall[0]), .redirect_valid_o(o_valid[0]), .redirect_pc_o(o_rpc[0]),
    .redirect_ready_i(ready));

  trap_ctrl #(.MTVEC_BASE(32'h0000_0100), .VECTORED(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .pc_i(pc),
    .illegal_insn_i(illegal), .ebreak_i(ebreak), .ecall_i(ecall), .mret_i(mret),
    .irq_ext_i(irq_ext), .irq_timer_i(irq_timer), .mie_i(mie), .epc_i(epc),
    .save_epc_o(o_save[1]), .epc_pc_o(o_epc[1]), .mcause_we_o(o_mcause_we[1]),
    .mcause_o(o_cause[1]), .restore_mie_o(o_restore[1]), .flush_o(o_flush[1]),
    .stall_o(o_stall[1]), .redirect_valid_o(o_valid[1]), .redirect_pc_o(o_rpc[1]),
    .redirect_ready_i(ready));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k]   = 1'b0;
      m_age[k]    = 0;
      m_mret[k]   = 1'b0;
      m_pc[k]     = 32'h0;
      m_cause[k]  = 32'h0;
      m_target[k] = 32'h0;
    end
  endtask

  // Advance the model by one clock edge from the inputs present at that edge.
  task automatic model_step();
    int          kind;
    logic [31:0] c;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 1'b0;
      end else if (!m_busy[k]) begin
        kind = 0;
        c    = 32'h0;
        if (instr_valid) begin
          if (illegal)               begin kind = 1; c = 32'h2; end
          else if (ebreak)           begin kind = 1; c = 32'h3; end
          else if (ecall)            begin kind = 1; c = 32'hB; end
          else if (mret)             begin kind = 2; end
          else if (mie && irq_ext)   begin kind = 3; c = 32'h8000_000B; end
          else if (mie && irq_timer) begin kind = 3; c = 32'h8000_0007; end
        end
        if (kind != 0) begin
          m_busy[k]   = 1'b1;
          m_age[k]    = 1;
          m_mret[k]   = (kind == 2);
          m_pc[k]     = pc;
          m_cause[k]  = c;
          m_target[k] = 32'h100 + ((kind == 3 && k == 1) ? (c % 32) * 4 : 0);
        end
      end else if (m_age[k] == 1) begin
        m_age[k] = 2;
        if (m_mret[k]) m_target[k] = epc;
      end else if (ready) begin
        m_busy[k] = 1'b0;
      end
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic compare_all();
    logic in_save, in_redir;
    for (int k = 0; k < 2; k++) begin
      in_save  = m_busy[k] && m_age[k] == 1;
      in_redir = m_busy[k] && m_age[k] >= 2;
      check($sformatf("save_epc%0d", k), {31'd0, o_save[k]}, {31'd0, in_save && !m_mret[k]});
      check($sformatf("mcause_we%0d", k), {31'd0, o_mcause_we[k]}, {31'd0, in_save && !m_mret[k]});
      check($sformatf("restore%0d", k), {31'd0, o_restore[k]}, {31'd0, in_save && m_mret[k]});
      check($sformatf("flush%0d", k), {31'd0, o_flush[k]}, {31'd0, in_save});
      check($sformatf("stall%0d", k), {31'd0, o_stall[k]}, {31'd0, m_busy[k]});
      check($sformatf("rvalid%0d", k), {31'd0, o_valid[k]}, {31'd0, in_redir});
      if (in_save && !m_mret[k]) begin
        check($sformatf("epc_pc%0d", k), o_epc[k], m_pc[k]);
        check($sformatf("mcause%0d", k), o_cause[k], m_cause[k]);
      end else if (!m_busy[k]) begin
        check($sformatf("epc_pc_idle%0d", k), o_epc[k], 32'h0);
        check($sformatf("mcause_idle%0d", k), o_cause[k], 32'h0);
      end
      if (in_redir) check($sformatf("rpc%0d", k), o_rpc[k], m_target[k]);
      else if (!m_busy[k]) check($sformatf("rpc_idle%0d", k), o_rpc[k], 32'h0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_in();
    instr_valid = 1'b0; illegal = 1'b0; ebreak = 1'b0; ecall = 1'b0; mret = 1'b0;
    irq_ext = 1'b0; irq_timer = 1'b0; mie = 1'b0; pc = 32'h0; epc = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    ready = 1'b1;
    clear_in();
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;

    // idle after reset
    repeat (10) tick();
    check("idle_stall", {31'd0, o_stall[0]}, 32'h0);

    // ecall at 0x2000, ready tied high
    instr_valid = 1'b1; ecall = 1'b1; pc = 32'h0000_2000;
    tick();
    clear_in();
    check("ecall_save", {31'd0, o_save[0]}, 32'h1);
    check("ecall_epc", o_epc[0], 32'h0000_2000);
    check("ecall_cause", o_cause[0], 32'h0000_000B);
    check("ecall_flush", {31'd0, o_flush[0]}, 32'h1);
    tick();
    check("ecall_rpc", o_rpc[0], 32'h0000_0100);
    check("ecall_rpc_vec", o_rpc[1], 32'h0000_0100);
    tick();
    check("ecall_back_idle", {31'd0, o_valid[0]}, 32'h0);
    tick();

    // ebreak beats ecall
    instr_valid = 1'b1; ebreak = 1'b1; ecall = 1'b1; pc = 32'h0000_0404;
    tick();
    clear_in();
    check("ebreak_cause", o_cause[0], 32'h0000_0003);
    repeat (3) tick();

    // illegal beats irq_ext; held irq_ext traps after return
    instr_valid = 1'b1; illegal = 1'b1; irq_ext = 1'b1; mie = 1'b1; pc = 32'h0000_0040;
    tick();
    check("illegal_cause", o_cause[0], 32'h0000_0002);
    illegal = 1'b0; pc = 32'h0000_0044;
    tick();
    tick();
    tick();
    check("irq_ext_cause", o_cause[0], 32'h8000_000B);
    check("irq_ext_epc", o_epc[0], 32'h0000_0044);
    clear_in();
    tick();
    check("irq_ext_rpc_vec", o_rpc[1], 32'h0000_012C);
    repeat (2) tick();

    // timer interrupt, vectored target
    instr_valid = 1'b1; irq_timer = 1'b1; mie = 1'b1; pc = 32'h0000_0800;
    tick();
    clear_in();
    check("timer_cause", o_cause[1], 32'h8000_0007);
    tick();
    check("timer_rpc_vec", o_rpc[1], 32'h0000_011C);
    check("timer_rpc_flat", o_rpc[0], 32'h0000_0100);
    repeat (2) tick();

    // same with MIE clear: nothing happens
    instr_valid = 1'b1; irq_timer = 1'b1; mie = 1'b0; pc = 32'h0000_0800;
    repeat (3) tick();
    check("masked_timer", {31'd0, o_stall[1]}, 32'h0);
    clear_in();

    // irq drops before an instruction arrives: no trap
    irq_ext = 1'b1; mie = 1'b1;
    tick();
    irq_ext = 1'b0; instr_valid = 1'b1;
    tick();
    check("irq_dropped", {31'd0, o_save[0]}, 32'h0);
    clear_in();
    tick();

    // mret with a slow fetch unit
    ready = 1'b0;
    instr_valid = 1'b1; mret = 1'b1; epc = 32'h0000_3004; mie = 1'b0;
    tick();
    instr_valid = 1'b0; mret = 1'b0;
    check("mret_restore", {31'd0, o_restore[0]}, 32'h1);
    check("mret_no_save", {31'd0, o_save[0]}, 32'h0);
    tick();
    epc = 32'h0000_DEAD;
    check("mret_rpc", o_rpc[0], 32'h0000_3004);
    check("mret_restore_once", {31'd0, o_restore[0]}, 32'h0);
    repeat (4) tick();
    check("mret_hold_valid", {31'd0, o_valid[0]}, 32'h1);
    check("mret_hold_rpc", o_rpc[1], 32'h0000_3004);
    ready = 1'b1;
    tick();
    check("mret_done", {31'd0, o_valid[0]}, 32'h0);
    clear_in();
    tick();

    // reset while redirecting
    ready = 1'b0;
    instr_valid = 1'b1; ecall = 1'b1; pc = 32'h0000_5000;
    tick();
    clear_in();
    tick();
    check("pre_reset_valid", {31'd0, o_valid[0]}, 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_valid", {31'd0, o_valid[0]}, 32'h0);
    check("reset_stall", {31'd0, o_stall[1]}, 32'h0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_reset_valid", {31'd0, o_valid[0]}, 32'h0);
    ready = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry and `mret` return for the single-issue core.
- Arbitrates synchronous exceptions and level-sensitive interrupts at the decode-stage instruction boundary.
- Drives the CSR file's EPC-save, mcause-write and MIE-restore strobes, then redirects fetch to the trap vector or the saved EPC.
- Sits between decode, the CSR block and the fetch unit; stalls the pipeline for the whole sequence.

Parameters:
- MTVEC_BASE, 32'h0000_0100, trap vector base address (must be 4-byte aligned).
- VECTORED, 0, 1 = interrupts jump to MTVEC_BASE + 4*cause[4:0]; 0 = all traps jump to MTVEC_BASE.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid_i  in  1  decode holds a valid instruction
- pc_i  in  32  PC of the decode-stage instruction
- illegal_insn_i  in  1  decode flags illegal instruction
- ebreak_i  in  1  decode flags EBREAK
- ecall_i  in  1  decode flags ECALL
- mret_i  in  1  decode flags MRET
- irq_ext_i  in  1  external interrupt, level
- irq_timer_i  in  1  timer interrupt, level
- mie_i  in  1  current mstatus.MIE from the CSR block
- epc_i  in  32  current mepc from the CSR block
- save_epc_o  out  1  CSR strobe: mepc <= epc_pc_o, MPIE <= MIE, MIE <= 0
- epc_pc_o  out  32  PC to save
- mcause_we_o  out  1  mcause write strobe
- mcause_o  out  32  cause value
- restore_mie_o  out  1  CSR strobe: MIE <= MPIE (mret)
- flush_o  out  1  kill the decode/fetch contents
- stall_o  out  1  hold the pipeline
- redirect_valid_o  out  1  fetch redirect request
- redirect_pc_o  out  32  redirect target
- redirect_ready_i  in  1  fetch accepts redirect

Behaviour:
- Reset: all outputs 0, state IDLE, latched pc/cause/target 0. Reset mid-sequence aborts it; any pending redirect is dropped.
- States: IDLE, SAVE, REDIRECT.
- IDLE: an event is evaluated only when instr_valid_i=1. Priority, highest first:
  - illegal: cause 32'h2
  - ebreak: cause 32'h3
  - ecall: cause 32'hB
  - mret
  - irq_ext (only if mie_i=1): cause 32'h8000_000B
  - irq_timer (only if mie_i=1): cause 32'h8000_0007
- On an event: latch pc_i, cause and a mret flag; go to SAVE. With no event, stay in IDLE with all outputs 0.
- Target computation, latched on entry to SAVE:
  - mret: epc_i sampled in SAVE.
  - Exception: MTVEC_BASE.
  - Interrupt: MTVEC_BASE + (VECTORED ? {cause[4:0],2'b00} : 0). Arithmetic is 32-bit and wraps modulo 2^32.
- SAVE (exactly 1 cycle): flush_o=1 and stall_o=1.
  - Trap: save_epc_o=1, epc_pc_o=latched pc, mcause_we_o=1, mcause_o=latched cause.
  - mret: restore_mie_o=1; save_epc_o=0 and mcause_we_o=0. The redirect target is epc_i sampled this cycle.
  - Next state is REDIRECT.
- REDIRECT: stall_o=1, redirect_valid_o=1, redirect_pc_o=target.
  - redirect_valid_o and redirect_pc_o stay stable until redirect_ready_i=1.
  - The cycle with valid&ready completes the handshake: next state IDLE, redirect_valid_o low the following cycle.
- Latency: event-detect cycle N → SAVE strobes at N+1 → redirect_valid_o at N+2. Minimum 3 cycles IDLE-to-IDLE.
- All inputs except redirect_ready_i and epc_i (read in SAVE) are ignored outside IDLE. Interrupts arriving mid-sequence stay pending (level) and are re-evaluated in IDLE.
- Interrupt levels are not latched. If an irq drops before instr_valid_i, no trap occurs.
- Exceptions and mret are never masked by mie_i.
- Outputs strobe_o/flush_o are registered-state decodes: no combinational path from any input to any output except via state.

Test Plan:
- Reset release, idle inputs → all outputs 0 for 10 cycles, stall_o=0.
- ecall_i=1 at pc 32'h0000_2000, ready tied 1 → next cycle save_epc_o=1, epc_pc_o=32'h2000, mcause_o=32'hB, flush_o=1; next cycle redirect_pc_o=32'h100; IDLE after.
- illegal_insn_i and irq_ext_i together with mie_i=1 → mcause_o=32'h2 (exception wins). irq_ext_i held → second trap with cause 32'h8000_000B after return to IDLE.
- VECTORED=1, irq_timer_i=1, mie_i=1 → redirect_pc_o=32'h0000_011C. Same stimulus with mie_i=0 → no trap.
- mret_i=1 with epc_i=32'h0000_3004 → restore_mie_o=1 for one cycle with no save_epc_o; redirect_pc_o=32'h3004. With redirect_ready_i low for 5 cycles, valid and pc stay stable, then IDLE.
- rst_n asserted while in REDIRECT → outputs 0 immediately. After release, redirect_valid_o stays 0 until a new event.
